// File: rtl/l2_cache_control_nway_if.sv
// Bundle of CPU request/response, physical memory handshake and L2
// datapath strobes exchanged with the N-way L2 cache controller.
interface l2_cache_control_nway_if #(
    parameter int WAYS = 4,
    parameter int SETS = 8
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = $clog2(SETS);

    logic             mem_read;
    logic             mem_write;
    logic [SET_W-1:0] set_idx;
    logic [WAYS-1:0]  hit;
    logic [WAYS-1:0]  valid;
    logic [WAYS-1:0]  dirty;
    logic             pmem_resp;

    logic             mem_resp;
    logic             pmem_read;
    logic             pmem_write;
    logic             mem_addr_sel;
    logic             mem_b_sel;
    logic [WAYS-1:0]  way_we;
    logic [WAYS-1:0]  ld_valid;
    logic [WAYS-1:0]  ld_dirty;
    logic             dirty_in;
    logic [WAY_W-1:0] victim_way;

    // Environment side: CPU/arbiter, physical memory and datapath
    modport master (
        output mem_read, mem_write, set_idx, hit, valid, dirty, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, mem_addr_sel, mem_b_sel,
        input  way_we, ld_valid, ld_dirty, dirty_in, victim_way
    );

    // Controller side
    modport slave (
        input  mem_read, mem_write, set_idx, hit, valid, dirty, pmem_resp,
        output mem_resp, pmem_read, pmem_write, mem_addr_sel, mem_b_sel,
        output way_we, ld_valid, ld_dirty, dirty_in, victim_way
    );
endinterface

// File: rtl/l2_cache_control_nway.sv
// N-way L2 cache controller: per-set tree-PLRU replacement, invalid-way-first
// victim choice, writeback before fill, saturating hit/miss statistics and a
// sticky multi-hit error flag.
module l2_cache_control_nway #(
    parameter int WAYS  = 4,
    parameter int SETS  = 8,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    l2_cache_control_nway_if.slave bus,
    input  logic                   clear_stats,
    output logic [CNT_W-1:0]       hit_count,
    output logic [CNT_W-1:0]       miss_count,
    output logic                   multi_hit_err
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int NODES = WAYS - 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITEBACK = 3'd1,
        FILL      = 3'd2,
        LOAD      = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [NODES-1:0]   plru_q [SETS];
    logic [NODES-1:0]   plru_d [SETS];
    logic               retry_q, retry_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic               multi_hit_q, multi_hit_d;
    logic               mem_resp_q, mem_resp_d;
    logic               pmem_read_q, pmem_read_d;
    logic               pmem_write_q, pmem_write_d;
    logic               addr_sel_q, addr_sel_d;
    logic               b_sel_q, b_sel_d;

    logic               request;
    logic               any_hit;
    logic               any_invalid;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   invalid_way;
    logic [WAY_W-1:0]   miss_victim;
    logic [NODES-1:0]   cur_plru;
    logic               hit_inc;
    logic               miss_inc;
    logic [WAYS-1:0]    way_we;
    logic [WAYS-1:0]    ld_valid;
    logic [WAYS-1:0]    ld_dirty;
    logic               dirty_in;

    // Point every node on way w's root-to-leaf path away from w.
    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] cur,
                                                    input logic [WAY_W-1:0] w);
        logic [NODES-1:0] r;
        r = cur;
        for (int d = 0; d < WAY_W; d++) begin
            for (int k = 0; k < (1 << d); k++) begin
                if ((int'(w) >> (WAY_W - d)) == k) begin
                    r[(1 << d) + k - 1] = ~w[WAY_W - 1 - d];
                end
            end
        end
        return r;
    endfunction

    // Follow the node bits from the root down to the pseudo-LRU leaf.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [NODES-1:0] cur);
        int   prefix;
        logic b;
        prefix = 0;
        for (int d = 0; d < WAY_W; d++) begin
            b = 1'b0;
            for (int k = 0; k < (1 << d); k++) begin
                if (prefix == k) begin
                    b = cur[(1 << d) + k - 1];
                end
            end
            prefix = prefix * 2 + int'(b);
        end
        return WAY_W'(prefix);
    endfunction

    // Decode the lookup: lowest hit way, lowest invalid way and miss victim.
    always_comb begin
        request     = bus.mem_read | bus.mem_write;
        any_hit     = |bus.hit;
        any_invalid = ~&bus.valid;
        hit_way     = '0;
        invalid_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (bus.hit[i]) begin
                hit_way = WAY_W'(i);
            end
            if (!bus.valid[i]) begin
                invalid_way = WAY_W'(i);
            end
        end
        cur_plru    = plru_q[bus.set_idx];
        miss_victim = any_invalid ? invalid_way : plru_victim(cur_plru);
    end

    // Next-state, bookkeeping and datapath strobes for the current state.
    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        victim_d    = victim_q;
        multi_hit_d = multi_hit_q;
        plru_d      = plru_q;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        way_we      = '0;
        ld_valid    = '0;
        ld_dirty    = '0;
        dirty_in    = 1'b0;
        case (state_q)
            IDLE: begin
                if (request) begin
                    if (any_hit) begin
                        if ((bus.hit & (bus.hit - WAYS'(1))) != '0) begin
                            multi_hit_d = 1'b1;
                        end
                        plru_d[bus.set_idx] = plru_touch(cur_plru, hit_way);
                        if (bus.mem_write) begin
                            way_we[hit_way]   = 1'b1;
                            ld_dirty[hit_way] = 1'b1;
                            dirty_in          = 1'b1;
                        end
                        hit_inc = ~retry_q;
                        retry_d = 1'b0;
                        state_d = RESP;
                    end else begin
                        victim_d = miss_victim;
                        miss_inc = 1'b1;
                        state_d  = (bus.valid[miss_victim] & bus.dirty[miss_victim])
                                   ? WRITEBACK : FILL;
                    end
                end else begin
                    retry_d = 1'b0;
                end
            end
            WRITEBACK: begin
                if (bus.pmem_resp) begin
                    ld_dirty[victim_q] = 1'b1;
                    state_d            = FILL;
                end
            end
            FILL: begin
                if (bus.pmem_resp) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                way_we[victim_q]   = 1'b1;
                ld_valid[victim_q] = 1'b1;
                ld_dirty[victim_q] = 1'b1;
                retry_d            = 1'b1;
                state_d            = IDLE;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!reset_n) begin
            way_we   = '0;
            ld_valid = '0;
            ld_dirty = '0;
            dirty_in = 1'b0;
        end
    end

    // Saturating statistics with clear taking priority, plus registered
    // Moore strobes decoded from the state being entered.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (clear_stats) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else begin
            if (hit_inc && (hit_cnt_q != '1)) begin
                hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end
            if (miss_inc && (miss_cnt_q != '1)) begin
                miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
        end
        mem_resp_d   = (state_d == RESP);
        pmem_read_d  = (state_d == FILL);
        pmem_write_d = (state_d == WRITEBACK);
        addr_sel_d   = (state_d == WRITEBACK);
        b_sel_d      = (state_d == LOAD);
    end

    // All controller state, cleared immediately by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= '0;
            end
            retry_q      <= 1'b0;
            victim_q     <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            multi_hit_q  <= 1'b0;
            mem_resp_q   <= 1'b0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            addr_sel_q   <= 1'b0;
            b_sel_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            plru_q       <= plru_d;
            retry_q      <= retry_d;
            victim_q     <= victim_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            multi_hit_q  <= multi_hit_d;
            mem_resp_q   <= mem_resp_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            addr_sel_q   <= addr_sel_d;
            b_sel_q      <= b_sel_d;
        end
    end

    assign bus.mem_resp     = mem_resp_q;
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.mem_addr_sel = addr_sel_q;
    assign bus.mem_b_sel    = b_sel_q;
    assign bus.way_we       = way_we;
    assign bus.ld_valid     = ld_valid;
    assign bus.ld_dirty     = ld_dirty;
    assign bus.dirty_in     = dirty_in;
    assign bus.victim_way   = victim_q;
    assign hit_count        = hit_cnt_q;
    assign miss_count       = miss_cnt_q;
    assign multi_hit_err    = multi_hit_q;
endmodule

// File: tb/tb_l2_cache_control_nway.sv
// Testbench for l2_cache_control_nway (4 ways, 8 sets, 4-bit counters)
// with a transaction-level reference model of replacement and statistics.
module tb_l2_cache_control_nway;
    localparam int WAYS    = 4;
    localparam int SETS    = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             clear_stats;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;
    logic             multi_hit_err;

    l2_cache_control_nway_if #(.WAYS(WAYS), .SETS(SETS)) ifc ();

    l2_cache_control_nway #(.WAYS(WAYS), .SETS(SETS), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (ifc),
        .clear_stats   (clear_stats),
        .hit_count     (hit_count),
        .miss_count    (miss_count),
        .multi_hit_err (multi_hit_err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int totalChecks  = 0;
    int passedChecks = 0;
    int failedChecks = 0;

    // Reference model: PLRU tree nodes 1..WAYS-1 per set, leaves WAYS..2*WAYS-1
    int plruM [SETS][WAYS];
    int hitM, missM, victimM;
    bit mhM, retryM;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        assert (observed === expected) passedChecks++;
        else begin
            failedChecks++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] packOut();
        return {12'b0, ifc.mem_resp, ifc.pmem_read, ifc.pmem_write, ifc.mem_addr_sel,
                ifc.mem_b_sel, ifc.way_we, ifc.ld_valid, ifc.ld_dirty, ifc.dirty_in,
                ifc.victim_way};
    endfunction

    // ctl = {mem_resp, pmem_read, pmem_write, mem_addr_sel, mem_b_sel}
    function automatic logic [31:0] expOut(input logic [4:0] ctl, input logic [3:0] we,
                                           input logic [3:0] lv, input logic [3:0] ld,
                                           input logic din, input int vic);
        logic [1:0] v2;
        v2 = vic[1:0];
        return {12'b0, ctl, we, lv, ld, din, v2};
    endfunction

    task automatic applyStimulus(input bit rd, input bit wr, input int s,
                                 input logic [3:0] h, input logic [3:0] v,
                                 input logic [3:0] d, input bit presp, input bit clr);
        @(negedge clk);
        ifc.mem_read  = rd;
        ifc.mem_write = wr;
        ifc.set_idx   = s[2:0];
        ifc.hit       = h;
        ifc.valid     = v;
        ifc.dirty     = d;
        ifc.pmem_resp = presp;
        clear_stats   = clr;
        #1;
    endtask

    function automatic int lowestSet(input logic [3:0] vec);
        for (int i = 0; i < WAYS; i++) begin
            if (vec[i]) return i;
        end
        return -1;
    endfunction

    function automatic int modelVictim(input int s);
        int node;
        node = 1;
        while (node < WAYS) node = 2 * node + plruM[s][node];
        return node - WAYS;
    endfunction

    task automatic modelTouch(input int s, input int w);
        int node;
        node = w + WAYS;
        while (node > 1) begin
            plruM[s][node / 2] = (node % 2 == 0) ? 1 : 0;
            node = node / 2;
        end
    endtask

    task automatic modelReset();
        for (int s = 0; s < SETS; s++)
            for (int n = 0; n < WAYS; n++) plruM[s][n] = 0;
        hitM = 0; missM = 0; victimM = 0; mhM = 1'b0; retryM = 1'b0;
    endtask

    task automatic checkStats(input string tag);
        checkOutput({tag, "_hits"}, 32'(hit_count), 32'(hitM));
        checkOutput({tag, "_misses"}, 32'(miss_count), 32'(missM));
        checkOutput({tag, "_mherr"}, 32'(multi_hit_err), 32'(mhM));
    endtask

    // Lookup that hits, the response cycle, then an idle cycle
    task automatic hitPhase(input bit wr, input int s, input logic [3:0] h,
                            input logic [3:0] v, input logic [3:0] d,
                            input bit clr, input string tag);
        int hw;
        logic [3:0] we;
        applyStimulus(!wr, wr, s, h, v, d, 1'b0, clr);
        hw = lowestSet(h);
        we = wr ? 4'(1 << hw) : 4'b0;
        checkOutput({tag, "_lookup"}, packOut(), expOut(5'b00000, we, 4'b0, we, wr, victimM));
        modelTouch(s, hw);
        if ($countones(h) > 1) mhM = 1'b1;
        if (clr) begin
            hitM = 0; missM = 0;
        end else if (!retryM) begin
            hitM = (hitM + 1 > CNT_MAX) ? CNT_MAX : hitM + 1;
        end
        retryM = 1'b0;
        applyStimulus(!wr, wr, s, h, v, d, 1'b0, 1'b0);
        checkOutput({tag, "_resp"}, packOut(), expOut(5'b10000, 4'b0, 4'b0, 4'b0, 1'b0, victimM));
        applyStimulus(1'b0, 1'b0, s, h, v, d, 1'b0, 1'b0);
        checkStats(tag);
    endtask

    // Lookup that misses, optional writeback, fill, load, then the retry
    task automatic missPhase(input bit wr, input int s, input logic [3:0] v,
                             input logic [3:0] d, input int wbWait, input int fillWait,
                             input bit dropOnRetry, input string tag);
        int inv;
        logic [3:0] vm;
        applyStimulus(!wr, wr, s, 4'b0, v, d, 1'b0, 1'b0);
        checkOutput({tag, "_lookup"}, packOut(), expOut(5'b00000, 4'b0, 4'b0, 4'b0, 1'b0, victimM));
        inv = lowestSet(~v);
        victimM = (inv >= 0) ? inv : modelVictim(s);
        missM = (missM + 1 > CNT_MAX) ? CNT_MAX : missM + 1;
        vm = 4'(1 << victimM);
        if (v[victimM] && d[victimM]) begin
            for (int i = 0; i < wbWait; i++) begin
                applyStimulus(!wr, wr, s, 4'b0, v, d, 1'b0, 1'b0);
                checkOutput({tag, "_wb_wait"}, packOut(), expOut(5'b00110, 4'b0, 4'b0, 4'b0, 1'b0, victimM));
            end
            applyStimulus(!wr, wr, s, 4'b0, v, d, 1'b1, 1'b0);
            checkOutput({tag, "_wb_done"}, packOut(), expOut(5'b00110, 4'b0, 4'b0, vm, 1'b0, victimM));
        end
        for (int i = 0; i < fillWait; i++) begin
            applyStimulus(!wr, wr, s, 4'b0, v, d, 1'b0, 1'b0);
            checkOutput({tag, "_fill_wait"}, packOut(), expOut(5'b01000, 4'b0, 4'b0, 4'b0, 1'b0, victimM));
        end
        applyStimulus(!wr, wr, s, 4'b0, v, d, 1'b1, 1'b0);
        checkOutput({tag, "_fill_done"}, packOut(), expOut(5'b01000, 4'b0, 4'b0, 4'b0, 1'b0, victimM));
        applyStimulus(!wr, wr, s, 4'b0, v, d, 1'b0, 1'b0);
        checkOutput({tag, "_load"}, packOut(), expOut(5'b00001, vm, vm, vm, 1'b0, victimM));
        retryM = 1'b1;
        if (dropOnRetry) begin
            applyStimulus(1'b0, 1'b0, s, vm, v | vm, d & ~vm, 1'b0, 1'b0);
            checkOutput({tag, "_dropped"}, packOut(), expOut(5'b00000, 4'b0, 4'b0, 4'b0, 1'b0, victimM));
            retryM = 1'b0;
            applyStimulus(1'b0, 1'b0, s, vm, v | vm, d & ~vm, 1'b0, 1'b0);
            checkOutput({tag, "_no_resp"}, packOut(), expOut(5'b00000, 4'b0, 4'b0, 4'b0, 1'b0, victimM));
            checkStats(tag);
        end else begin
            hitPhase(wr, s, vm, v | vm, d & ~vm, 1'b0, {tag, "_retry"});
        end
    endtask

    // Bound the whole run
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: run did not finish within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed steps, randomized traffic, mid-fill reset and counter limits
    initial begin
        modelReset();
        ifc.mem_read  = 1'b0;
        ifc.mem_write = 1'b1;
        ifc.set_idx   = 3'd0;
        ifc.hit       = 4'b0001;
        ifc.valid     = 4'hF;
        ifc.dirty     = 4'h0;
        ifc.pmem_resp = 1'b0;
        clear_stats   = 1'b0;
        #12;
        checkOutput("reset_strobes", packOut(), 32'h0);
        checkStats("reset");
        @(negedge clk);
        reset_n       = 1'b1;
        ifc.mem_write = 1'b0;
        ifc.hit       = 4'b0;

        $display("[TB] directed lookups");
        hitPhase(1'b0, 3, 4'b0100, 4'hF, 4'h0, 1'b0, "rd_hit_w2");
        missPhase(1'b0, 3, 4'hF, 4'h0, 0, 0, 1'b0, "plru_after_w2");
        missPhase(1'b0, 1, 4'b0011, 4'h0, 0, 2, 1'b0, "cold_miss");
        missPhase(1'b1, 5, 4'hF, 4'b0001, 1, 0, 1'b0, "wr_miss_wb");
        for (int w = 0; w < WAYS; w++) hitPhase(1'b0, 6, 4'(1 << w), 4'hF, 4'h0, 1'b0, "seq_hit");
        missPhase(1'b0, 6, 4'hF, 4'h0, 0, 1, 1'b0, "seq_miss");
        hitPhase(1'b0, 6, 4'b0011, 4'hF, 4'h0, 1'b0, "multi_hit");
        missPhase(1'b0, 7, 4'b0111, 4'h0, 0, 0, 1'b1, "retry_drop");
        hitPhase(1'b0, 7, 4'b1000, 4'hF, 4'h0, 1'b0, "after_drop");

        $display("[TB] randomized traffic");
        for (int n = 0; n < 40; n++) begin
            int  s;
            bit  wr;
            logic [3:0] v;
            s  = int'($urandom_range(0, SETS - 1));
            wr = bit'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                hitPhase(wr, s, 4'(1 << $urandom_range(0, WAYS - 1)), 4'hF,
                         4'($urandom_range(0, 15)), 1'b0, "rnd_hit");
            end else begin
                v = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
                missPhase(wr, s, v, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 3)), 1'b0, "rnd_miss");
            end
        end

        $display("[TB] reset during fill");
        applyStimulus(1'b1, 1'b0, 2, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
        checkOutput("abort_fill", packOut(), expOut(5'b01000, 4'b0, 4'b0, 4'b0, 1'b0, 0));
        #2;
        reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("abort_strobes", packOut(), 32'h0);
        checkStats("abort");
        @(negedge clk);
        reset_n       = 1'b1;
        ifc.mem_read  = 1'b0;

        $display("[TB] counter saturation and clear");
        for (int n = 0; n < 16; n++) hitPhase(1'b0, 0, 4'b0010, 4'hF, 4'h0, 1'b0, "sat_hit");
        hitPhase(1'b1, 0, 4'b0010, 4'hF, 4'h0, 1'b1, "clear_hit");

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end
endmodule

// File: doc/l2_cache_control_nway.md
Name: l2_cache_control_nway

Overview:
- Parametrised N-way successor to the 2-way L2 cache controller.
- Sits between the L1/arbiter request port and physical memory, and drives per-way write, valid and dirty strobes into the L2 datapath.
- Adds per-set tree-PLRU state held inside the controller, invalid-way-first victim selection, and writeback-before-fill ordering.
- Adds hit/miss statistics counters and a multi-hit error flag.

Parameters:
- WAYS, 4, associativity; power of two, 2..8.
- SETS, 8, number of sets; power of two.
- CNT_W, 32, width of the hit/miss statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  CPU-side read request, held until mem_resp.
- mem_write  in  1  CPU-side write request, held until mem_resp.
- set_idx  in  $clog2(SETS)  set index of the current request, stable while the request is held.
- hit  in  WAYS  per-way tag match from the datapath.
- valid  in  WAYS  per-way valid bits of the indexed set.
- dirty  in  WAYS  per-way dirty bits of the indexed set.
- pmem_resp  in  1  physical memory done.
- clear_stats  in  1  synchronous clear of the statistics counters.
- mem_resp  out  1  one-cycle done pulse to the CPU.
- pmem_read  out  1  fill request to physical memory.
- pmem_write  out  1  writeback request to physical memory.
- mem_addr_sel  out  1  1 selects the victim writeback address, 0 selects the CPU address.
- mem_b_sel  out  1  1 selects the full-line byte enable for a fill.
- way_we  out  WAYS  per-way data write enable.
- ld_valid  out  WAYS  per-way valid load; loaded value is always 1.
- ld_dirty  out  WAYS  per-way dirty load, value given by dirty_in.
- dirty_in  out  1  dirty value written by ld_dirty.
- victim_way  out  $clog2(WAYS)  latched victim way, drives the eviction tag/data mux.
- hit_count  out  CNT_W  saturating count of first-lookup hits.
- miss_count  out  CNT_W  saturating count of misses.
- multi_hit_err  out  1  sticky; set when more than one hit bit is asserted during a lookup.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; PLRU array = 0; counters = 0; victim_way = 0; retry flag = 0; multi_hit_err = 0.
  - Every strobe output is 0.
- Outputs are Moore/Mealy from the current state. All strobe defaults are 0.
- State IDLE, request present (mem_read | mem_write):
  - Hit:
    - h = lowest set bit of hit.
    - If popcount(hit) > 1, set multi_hit_err.
    - Update PLRU[set_idx] toward h.
    - On a write: way_we[h] = 1, ld_dirty[h] = 1, dirty_in = 1.
    - If the retry flag is 0, increment hit_count.
    - Clear the retry flag; next state RESP.
  - Miss:
    - Latch victim_way as follows: the lowest-index way with valid = 0 if any; otherwise the PLRU victim of set_idx.
    - Increment miss_count.
    - Next state WRITEBACK if valid[v] & dirty[v], else FILL.
- State IDLE, no request: clear the retry flag; stay in IDLE.
- WRITEBACK:
  - pmem_write = 1, mem_addr_sel = 1.
  - On pmem_resp: ld_dirty[v] = 1, dirty_in = 0; next state FILL.
  - Otherwise stay in WRITEBACK.
- FILL:
  - pmem_read = 1, mem_addr_sel = 0.
  - On pmem_resp go to LOAD, otherwise stay in FILL.
- LOAD:
  - mem_b_sel = 1, way_we[v] = 1, ld_valid[v] = 1, ld_dirty[v] = 1, dirty_in = 0.
  - Set the retry flag; next state IDLE.
  - The re-lookup then hits and performs any write-data merge and the dirty set.
- RESP: mem_resp = 1; next state IDLE. The request is sampled again only on the following cycle.
- PLRU, per set:
  - WAYS-1 bits forming a heap: root is node 1, children of node n are 2n and 2n+1; node n is stored at bit n-1.
  - Victim walk starts at the root: bit 0 goes left (lower ways), bit 1 goes right.
  - Access to way w: every node on w's path is set to point away from w (1 if w is in the left subtree, else 0).
  - The update is registered and visible from the next cycle.
- Counters saturate at all-ones. clear_stats has priority over increment in the same cycle.
- Latency:
  - Read or write hit: mem_resp in the 2nd cycle after the request is seen.
  - Clean miss: 1 + fill cycles + 1 (LOAD) + 2.
- The request must stay asserted until mem_resp. If it drops during the IDLE retry, return to IDLE with no mem_resp and no extra count.
- Reset mid-WRITEBACK/FILL aborts immediately. The line state in the datapath is unspecified; PLRU and counters are cleared.

Test Plan:
- Reset: reset_n low with request asserted -> all strobes 0, victim_way 0, counters 0; release -> IDLE.
- WAYS=4, read with hit=4'b0100 -> cycle 2 mem_resp; PLRU[set] = 3'b100 (root right→left); hit_count = 1.
- Cold read miss with valid=4'b0011 -> victim_way = 2, no pmem_write; FILL held 3 cycles until pmem_resp; LOAD with way_we = 4'b0100; retry hit; single mem_resp; miss_count = 1, hit_count = 0.
- Write miss, all valid, PLRU = 0, dirty[0] = 1 -> victim 0; WRITEBACK with mem_addr_sel = 1 and dirty clear; FILL; LOAD; retry write sets ld_dirty[0] with dirty_in = 1.
- Sequential hits on ways 0,1,2,3 then a miss (all valid) -> victim_way = 0; hit = 4'b0011 sets multi_hit_err.
- Counter with CNT_W=4: 16 hits -> hit_count stays 15; clear_stats asserted together with a hit -> 0.
